// File: rtl/pipe_control_unit_if.sv
// Decode-to-EX control bundle between the pipeline datapath (master) and
// the pipe control unit (slave).
interface pipe_control_unit_if #(
  parameter int OPCODE_W = 5,
  parameter int REG_W    = 3,
  parameter int CNT_W    = 16
);
  logic                id_valid;
  logic [OPCODE_W-1:0] id_opcode;
  logic [REG_W-1:0]    id_rs;
  logic [REG_W-1:0]    id_rt;
  logic [REG_W-1:0]    id_rd;
  logic                flag_z;
  logic                flag_l;
  logic                flag_g;

  logic                ex_reg_write;
  logic                ex_is_move;
  logic                ex_is_mem_access;
  logic                ex_is_imm;
  logic                ex_flags_write;
  logic                ex_dm_write;
  logic [2:0]          ex_alu_func;
  logic [REG_W-1:0]    ex_rd;
  logic                stall;
  logic                flush;
  logic                branch_taken;
  logic                illegal_op;
  logic [CNT_W-1:0]    stall_count;

  modport master (
    output id_valid, id_opcode, id_rs, id_rt, id_rd, flag_z, flag_l, flag_g,
    input  ex_reg_write, ex_is_move, ex_is_mem_access, ex_is_imm,
           ex_flags_write, ex_dm_write, ex_alu_func, ex_rd,
           stall, flush, branch_taken, illegal_op, stall_count
  );

  modport slave (
    input  id_valid, id_opcode, id_rs, id_rt, id_rd, flag_z, flag_l, flag_g,
    output ex_reg_write, ex_is_move, ex_is_mem_access, ex_is_imm,
           ex_flags_write, ex_dm_write, ex_alu_func, ex_rd,
           stall, flush, branch_taken, illegal_op, stall_count
  );
endinterface

// File: rtl/pipe_control_unit.sv
// Decode and EX-stage control register with load-use stall, branch flush,
// sticky illegal-opcode flag and a saturating stall counter.
module pipe_control_unit #(
  parameter int OPCODE_W = 5,
  parameter int REG_W    = 3,
  parameter int CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pipe_control_unit_if.slave   bus
);

  typedef enum logic [4:0] {
    OP_NOP  = 5'd0,  OP_ADD  = 5'd1,  OP_SUB  = 5'd2,  OP_OR   = 5'd3,
    OP_AND  = 5'd4,  OP_XOR  = 5'd5,  OP_MOV  = 5'd6,  OP_LW   = 5'd7,
    OP_SW   = 5'd8,  OP_LI   = 5'd9,  OP_ADDI = 5'd10, OP_SUBI = 5'd11,
    OP_CMP  = 5'd12, OP_JZ   = 5'd13, OP_JNZ  = 5'd14, OP_JG   = 5'd15,
    OP_JL   = 5'd16, OP_JUMP = 5'd17
  } opcode_e;

  typedef struct packed {
    logic       reg_write;
    logic       is_move;
    logic       is_mem_access;
    logic       is_imm;
    logic       flags_write;
    logic       dm_write;
    logic [2:0] alu_func;
    logic       jz;
    logic       jnz;
    logic       jg;
    logic       jl;
    logic       jump;
  } ctrl_t;

  ctrl_t            dec_ctrl;
  logic             dec_illegal;
  logic             upper_nz;
  logic             hazard;
  logic             branch_taken;
  logic             stall;
  logic             load_bubble;

  ctrl_t            ex_d, ex_q;
  logic [REG_W-1:0] ex_rd_d, ex_rd_q;
  logic             illegal_d, illegal_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  assign upper_nz = (bus.id_opcode >> 5) != '0;

  // NOTE: every output of a combinational block gets a default first so no path
  // through the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    dec_ctrl    = '0;
    dec_illegal = 1'b0;
    if (bus.id_valid) begin
      if (upper_nz) begin
        dec_illegal = 1'b1;
      end else begin
        case (opcode_e'(bus.id_opcode[4:0]))
          OP_NOP:  ;
          OP_ADD, OP_SUB, OP_OR, OP_AND, OP_XOR: begin
            dec_ctrl.reg_write   = 1'b1;
            dec_ctrl.flags_write = 1'b1;
            dec_ctrl.alu_func    = bus.id_opcode[2:0];
          end
          OP_MOV:  begin dec_ctrl.reg_write = 1'b1; dec_ctrl.is_move = 1'b1; end
          OP_LW:   begin dec_ctrl.reg_write = 1'b1; dec_ctrl.is_mem_access = 1'b1; end
          OP_SW:   dec_ctrl.dm_write = 1'b1;
          OP_LI:   begin dec_ctrl.reg_write = 1'b1; dec_ctrl.is_imm = 1'b1; end
          OP_ADDI, OP_SUBI: begin
            dec_ctrl.reg_write   = 1'b1;
            dec_ctrl.is_imm      = 1'b1;
            dec_ctrl.flags_write = 1'b1;
            dec_ctrl.alu_func    = (bus.id_opcode[4:0] == OP_ADDI) ? 3'd1 : 3'd2;
          end
          OP_CMP:  begin dec_ctrl.flags_write = 1'b1; dec_ctrl.alu_func = 3'd2; end
          OP_JZ:   dec_ctrl.jz   = 1'b1;
          OP_JNZ:  dec_ctrl.jnz  = 1'b1;
          OP_JG:   dec_ctrl.jg   = 1'b1;
          OP_JL:   dec_ctrl.jl   = 1'b1;
          OP_JUMP: dec_ctrl.jump = 1'b1;
          default: dec_illegal = 1'b1;
        endcase
      end
    end
  end

  // A load in EX can only be identified by is_mem_access; stores use dm_write alone.
  assign hazard = ex_q.is_mem_access && bus.id_valid &&
                  ((ex_rd_q == bus.id_rs) || (ex_rd_q == bus.id_rt));

  assign branch_taken = ex_q.jump | (ex_q.jz & bus.flag_z) | (ex_q.jnz & ~bus.flag_z) |
                        (ex_q.jg & bus.flag_g) | (ex_q.jl & bus.flag_l);

  // A taken branch squashes the instruction in decode, so its hazard is moot.
  assign stall       = hazard & ~branch_taken;
  assign load_bubble = stall | branch_taken | ~bus.id_valid;

  always_comb begin
    ex_d      = load_bubble ? '0 : dec_ctrl;
    ex_rd_d   = load_bubble ? '0 : bus.id_rd;
    illegal_d = illegal_q | dec_illegal;
    cnt_d     = (stall && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q      <= '0;
      ex_rd_q   <= '0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      ex_q      <= ex_d;
      ex_rd_q   <= ex_rd_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.ex_reg_write     = ex_q.reg_write;
  assign bus.ex_is_move       = ex_q.is_move;
  assign bus.ex_is_mem_access = ex_q.is_mem_access;
  assign bus.ex_is_imm        = ex_q.is_imm;
  assign bus.ex_flags_write   = ex_q.flags_write;
  assign bus.ex_dm_write      = ex_q.dm_write;
  assign bus.ex_alu_func      = ex_q.alu_func;
  assign bus.ex_rd            = ex_rd_q;
  assign bus.stall            = stall;
  assign bus.flush            = branch_taken;
  assign bus.branch_taken     = branch_taken;
  assign bus.illegal_op       = illegal_q;
  assign bus.stall_count      = cnt_q;

endmodule

// File: tb/tb_pipe_control_unit.sv
// Directed bench for pipe_control_unit: vector table plus hand-written reset,
// stall-saturation and mid-branch sequences on a default and a CNT_W=2 instance.
module tb_pipe_control_unit;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  pipe_control_unit_if #(.OPCODE_W(5), .REG_W(3), .CNT_W(16)) u_if ();
  pipe_control_unit_if #(.OPCODE_W(5), .REG_W(3), .CNT_W(2))  u_if2 ();

  assign u_if2.id_valid  = u_if.id_valid;
  assign u_if2.id_opcode = u_if.id_opcode;
  assign u_if2.id_rs     = u_if.id_rs;
  assign u_if2.id_rt     = u_if.id_rt;
  assign u_if2.id_rd     = u_if.id_rd;
  assign u_if2.flag_z    = u_if.flag_z;
  assign u_if2.flag_l    = u_if.flag_l;
  assign u_if2.flag_g    = u_if.flag_g;

  pipe_control_unit #(.OPCODE_W(5), .REG_W(3), .CNT_W(16)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if)
  );

  pipe_control_unit #(.OPCODE_W(5), .REG_W(3), .CNT_W(2)) u_dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       valid;
    logic [4:0] op;
    logic [2:0] rs, rt, rd;
    logic       z, l, g;
    logic       exp_stall;
    logic       exp_flush;
    logic [5:0] exp_ctl;   // {reg_write, is_move, is_mem_access, is_imm, flags_write, dm_write}
    logic [2:0] exp_alu;
    logic [2:0] exp_rd;
    logic       exp_ill;
    logic [15:0] exp_sc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic v, logic [4:0] op, logic [2:0] rs, logic [2:0] rt,
                              logic [2:0] rd, logic z, logic l, logic g,
                              logic s, logic f, logic [5:0] ctl, logic [2:0] alu,
                              logic [2:0] exrd, logic ill, logic [15:0] sc);
    vec_t r;
    r.valid = v; r.op = op; r.rs = rs; r.rt = rt; r.rd = rd;
    r.z = z; r.l = l; r.g = g;
    r.exp_stall = s; r.exp_flush = f; r.exp_ctl = ctl; r.exp_alu = alu;
    r.exp_rd = exrd; r.exp_ill = ill; r.exp_sc = sc;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] op, input logic [2:0] rs,
                       input logic [2:0] rt, input logic [2:0] rd,
                       input logic z, input logic l, input logic g);
    u_if.id_valid  = v;
    u_if.id_opcode = op;
    u_if.id_rs     = rs;
    u_if.id_rt     = rt;
    u_if.id_rd     = rd;
    u_if.flag_z    = z;
    u_if.flag_l    = l;
    u_if.flag_g    = g;
  endtask

  function automatic logic [11:0] ex_bundle();
    return {u_if.ex_reg_write, u_if.ex_is_move, u_if.ex_is_mem_access, u_if.ex_is_imm,
            u_if.ex_flags_write, u_if.ex_dm_write, u_if.ex_alu_func, u_if.ex_rd};
  endfunction

  initial begin
    // Columns: valid op rs rt rd z l g | stall flush | ctl alu ex_rd ill stall_count
    vecs.push_back(mk(1, 5'd1,  1, 2, 3, 0, 0, 0, 0, 0, 6'b100010, 1, 3, 0, 0)); // ADD
    vecs.push_back(mk(1, 5'd7,  0, 0, 2, 0, 0, 0, 0, 0, 6'b101000, 0, 2, 0, 0)); // LW r2
    vecs.push_back(mk(1, 5'd1,  2, 5, 4, 0, 0, 0, 1, 0, 6'b000000, 0, 0, 0, 1)); // ADD rs=r2 stalls
    vecs.push_back(mk(1, 5'd1,  2, 5, 4, 0, 0, 0, 0, 0, 6'b100010, 1, 4, 0, 1)); // ADD proceeds
    vecs.push_back(mk(1, 5'd6,  4, 0, 1, 0, 0, 0, 0, 0, 6'b110000, 0, 1, 0, 1)); // MOV
    vecs.push_back(mk(1, 5'd8,  1, 2, 5, 0, 0, 0, 0, 0, 6'b000001, 0, 5, 0, 1)); // SW
    vecs.push_back(mk(1, 5'd9,  0, 0, 6, 0, 0, 0, 0, 0, 6'b100100, 0, 6, 0, 1)); // LI
    vecs.push_back(mk(1, 5'd10, 0, 0, 7, 0, 0, 0, 0, 0, 6'b100110, 1, 7, 0, 1)); // ADDI
    vecs.push_back(mk(1, 5'd11, 0, 0, 1, 0, 0, 0, 0, 0, 6'b100110, 2, 1, 0, 1)); // SUBI
    vecs.push_back(mk(1, 5'd12, 0, 0, 2, 0, 0, 0, 0, 0, 6'b000010, 2, 2, 0, 1)); // CMP
    vecs.push_back(mk(1, 5'd3,  0, 0, 3, 0, 0, 0, 0, 0, 6'b100010, 3, 3, 0, 1)); // OR
    vecs.push_back(mk(1, 5'd4,  0, 0, 4, 0, 0, 0, 0, 0, 6'b100010, 4, 4, 0, 1)); // AND
    vecs.push_back(mk(1, 5'd5,  0, 0, 5, 0, 0, 0, 0, 0, 6'b100010, 5, 5, 0, 1)); // XOR
    vecs.push_back(mk(1, 5'd13, 0, 0, 0, 1, 0, 0, 0, 0, 6'b000000, 0, 0, 0, 1)); // JZ
    vecs.push_back(mk(1, 5'd1,  1, 1, 3, 1, 0, 0, 0, 1, 6'b000000, 0, 0, 0, 1)); // JZ taken
    vecs.push_back(mk(1, 5'd13, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 0, 1)); // JZ
    vecs.push_back(mk(1, 5'd1,  1, 1, 3, 0, 0, 0, 0, 0, 6'b100010, 1, 3, 0, 1)); // JZ not taken
    vecs.push_back(mk(1, 5'd14, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 0, 1)); // JNZ
    vecs.push_back(mk(1, 5'd0,  0, 0, 0, 0, 0, 0, 0, 1, 6'b000000, 0, 0, 0, 1)); // JNZ taken
    vecs.push_back(mk(1, 5'd15, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 0, 1)); // JG
    vecs.push_back(mk(1, 5'd0,  0, 0, 0, 0, 0, 1, 0, 1, 6'b000000, 0, 0, 0, 1)); // JG taken
    vecs.push_back(mk(1, 5'd16, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 0, 1)); // JL
    vecs.push_back(mk(1, 5'd0,  0, 0, 0, 0, 0, 1, 0, 0, 6'b000000, 0, 0, 0, 1)); // JL not taken
    vecs.push_back(mk(1, 5'd17, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 0, 1)); // JUMP
    vecs.push_back(mk(1, 5'd0,  0, 0, 0, 0, 0, 0, 0, 1, 6'b000000, 0, 0, 0, 1)); // JUMP taken
    vecs.push_back(mk(1, 5'd7,  0, 0, 2, 0, 0, 0, 0, 0, 6'b101000, 0, 2, 0, 1)); // LW r2
    vecs.push_back(mk(1, 5'd13, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 0, 1)); // JZ
    vecs.push_back(mk(1, 5'd1,  2, 2, 3, 1, 0, 0, 0, 1, 6'b000000, 0, 0, 0, 1)); // flush, no stall
    vecs.push_back(mk(1, 5'd20, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 1, 1)); // illegal
    vecs.push_back(mk(0, 5'd1,  1, 1, 3, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 1, 1)); // invalid: bubble
    vecs.push_back(mk(1, 5'd7,  0, 0, 6, 0, 0, 0, 0, 0, 6'b101000, 0, 6, 1, 1)); // LW r6
    vecs.push_back(mk(1, 5'd2,  1, 6, 7, 0, 0, 0, 1, 0, 6'b000000, 0, 0, 1, 2)); // SUB rt=r6 stalls
    vecs.push_back(mk(1, 5'd2,  1, 6, 7, 0, 0, 0, 0, 0, 6'b100010, 2, 7, 1, 2)); // SUB proceeds
    vecs.push_back(mk(1, 5'd7,  0, 0, 1, 0, 0, 0, 0, 0, 6'b101000, 0, 1, 1, 2)); // LW r1
    vecs.push_back(mk(0, 5'd2,  1, 1, 3, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 1, 2)); // invalid: no stall

    drive(0, 5'd0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("reset_ex", {20'd0, ex_bundle()}, 32'd0);
    check("reset_illegal", {31'd0, u_if.illegal_op}, 32'd0);
    check("reset_stall_count", {16'd0, u_if.stall_count}, 32'd0);
    check("reset_stall_flush", {30'd0, u_if.stall, u_if.flush}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].valid, vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].rd,
            vecs[i].z, vecs[i].l, vecs[i].g);
      #2;
      check($sformatf("v%0d_stall", i), {31'd0, u_if.stall}, {31'd0, vecs[i].exp_stall});
      check($sformatf("v%0d_flush", i), {31'd0, u_if.flush}, {31'd0, vecs[i].exp_flush});
      check($sformatf("v%0d_branch", i), {31'd0, u_if.branch_taken}, {31'd0, vecs[i].exp_flush});
      @(posedge clk);
      #1;
      check($sformatf("v%0d_ex", i), {20'd0, ex_bundle()},
            {20'd0, vecs[i].exp_ctl, vecs[i].exp_alu, vecs[i].exp_rd});
      check($sformatf("v%0d_illegal", i), {31'd0, u_if.illegal_op}, {31'd0, vecs[i].exp_ill});
      check($sformatf("v%0d_stall_count", i), {16'd0, u_if.stall_count}, {16'd0, vecs[i].exp_sc});
    end

    // Sticky illegal flag survives idle cycles, then clears on reset.
    drive(0, 5'd0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("illegal_sticky", {31'd0, u_if.illegal_op}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("illegal_reset", {31'd0, u_if.illegal_op}, 32'd0);
    check("count_reset", {16'd0, u_if.stall_count}, 32'd0);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Repeated LW-use hazards: narrow counter saturates at 3.
    drive(1, 5'd7, 0, 0, 2, 0, 0, 0);
    @(posedge clk);
    #1;
    for (int k = 1; k <= 5; k++) begin
      drive(1, 5'd7, 2, 0, 2, 0, 0, 0);
      #2;
      check($sformatf("sat%0d_stall", k), {31'd0, u_if.stall}, 32'd1);
      @(posedge clk);
      #1;
      check($sformatf("sat%0d_count16", k), {16'd0, u_if.stall_count}, k);
      check($sformatf("sat%0d_count2", k), {30'd0, u_if2.stall_count}, (k > 3) ? 3 : k);
      #2;
      check($sformatf("sat%0d_release", k), {31'd0, u_if.stall}, 32'd0);
      @(posedge clk);
      #1;
    end

    // Reset in the middle of a stall.
    #2;
    check("midstall_pre", {31'd0, u_if.stall}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("midstall_stall", {31'd0, u_if.stall}, 32'd0);
    check("midstall_count16", {16'd0, u_if.stall_count}, 32'd0);
    check("midstall_count2", {30'd0, u_if2.stall_count}, 32'd0);
    check("midstall_ex", {20'd0, ex_bundle()}, 32'd0);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("resume_ex", {20'd0, ex_bundle()}, {20'd0, 6'b101000, 3'd0, 3'd2});

    // Reset in the middle of a taken branch.
    drive(1, 5'd13, 0, 0, 0, 1, 0, 0);
    @(posedge clk);
    #1;
    drive(1, 5'd0, 0, 0, 0, 1, 0, 0);
    #1;
    check("midbranch_pre", {30'd0, u_if.flush, u_if.branch_taken}, 32'd3);
    rst_n = 1'b0;
    #1;
    check("midbranch_reset", {30'd0, u_if.flush, u_if.branch_taken}, 32'd0);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_control_unit.md
PIPE_CONTROL_UNIT -- requirements
Module: pipe_control_unit

Interface
REQ-001 The block SHALL have parameter OPCODE_W, default 5, opcode field width (values >= 5 only).
REQ-002 The block SHALL have parameter REG_W, default 3, register-address width.
REQ-003 The block SHALL have parameter CNT_W, default 16, stall-counter width.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 id_valid  input  1  decode-stage instruction is valid.
REQ-008 id_opcode  input  OPCODE_W  decode-stage opcode.
REQ-009 id_rs, id_rt  input  REG_W each  decode-stage source registers.
REQ-010 id_rd  input  REG_W  decode-stage destination register.
REQ-011 flag_z, flag_l, flag_g  input  1 each  architectural flags (zero, less, greater).
REQ-012 ex_reg_write, ex_is_move, ex_is_mem_access, ex_is_imm, ex_flags_write, ex_dm_write  output  1 each  registered EX-stage controls.
REQ-013 ex_alu_func  output  3  registered ALU function.
REQ-014 ex_rd  output  REG_W  registered destination.
REQ-015 stall  output  1  hold fetch/decode this cycle.
REQ-016 flush  output  1  squash fetch/decode this cycle.
REQ-017 branch_taken  output  1  EX-stage jump resolved taken.
REQ-018 illegal_op  output  1  sticky flag: an undefined opcode was decoded.
REQ-019 stall_count  output  CNT_W  saturating count of stall cycles.

Function
REQ-020 Opcode map: 0 NOP, 1 ADD, 2 SUB, 3 OR, 4 AND, 5 XOR, 6 MOV, 7 LW, 8 SW, 9 LI, 10 ADDI, 11 SUBI, 12 CMP, 13 JZ, 14 JNZ, 15 JG, 16 JL, 17 JUMP; upper opcode bits beyond bit 4 SHALL be zero for a defined opcode.
REQ-021 Decode: ALU ops 1-5 SHALL set reg_write, flags_write, alu_func = opcode; MOV SHALL set reg_write, is_move; LW SHALL set reg_write, is_mem_access; SW SHALL set dm_write; LI SHALL set reg_write, is_imm; ADDI/SUBI SHALL set reg_write, is_imm, flags_write, alu_func 1/2.
REQ-022 CMP SHALL set flags_write and alu_func 2 with reg_write 0 (no register write-back).
REQ-023 Jumps SHALL set exactly one internal EX jump-type bit (jz, jnz, jg, jl, jump); all other controls 0.
REQ-024 Each clk edge with no stall/flush, the EX register SHALL load the decoded controls and id_rd; latency decode-to-EX outputs = 1 cycle.
REQ-025 id_valid = 0 SHALL load a bubble (all controls 0, ex_rd 0).
REQ-026 Load-use hazard: stall SHALL be 1 combinationally when EX holds LW, id_valid = 1, and ex_rd equals id_rs or id_rt.
REQ-027 While stall = 1 the EX register SHALL load a bubble; upstream holds the decode instruction.
REQ-028 branch_taken SHALL be combinational from EX: jump | (jz & flag_z) | (jnz & ~flag_z) | (jg & flag_g) | (jl & flag_l).
REQ-029 flush SHALL equal branch_taken; while flush = 1 the EX register SHALL load a bubble.
REQ-030 Simultaneous stall and flush: flush SHALL win; stall SHALL be forced to 0.
REQ-031 An undefined opcode (>= 18) with id_valid = 1 SHALL decode as NOP and set illegal_op on the next edge; illegal_op stays 1 until reset.
REQ-032 stall_count SHALL increment by 1 each cycle stall = 1 and saturate at all-ones.

Reset
REQ-033 rst_n = 0 SHALL immediately clear all EX controls, ex_rd, illegal_op and stall_count to 0, independent of clk.
REQ-034 Reset mid-stall or mid-branch SHALL drop stall, flush, branch_taken to 0 at once; operation resumes on the first edge after rst_n = 1.

Verification
REQ-035 ADD (1) valid, rd=3 -> next cycle ex_reg_write=1, ex_flags_write=1, ex_alu_func=1, ex_rd=3.
REQ-036 LW rd=2 then ADD rs=2 -> stall=1 one cycle, EX bubble, stall_count=1, ADD reaches EX the cycle after.
REQ-037 JZ in EX with flag_z=1 -> branch_taken=1, flush=1, next EX is bubble; flag_z=0 -> both 0.
REQ-038 JZ taken in EX while LW-use hazard in decode -> flush=1, stall=0, stall_count unchanged.
REQ-039 opcode 20 valid -> EX controls all 0, illegal_op=1 next cycle and remains 1 until rst_n=0.
REQ-040 CNT_W=2, hold hazard 5 cycles -> stall_count 1,2,3,3,3; rst_n pulse mid-sequence -> stall_count 0 immediately.
